// File: rtl/motion_pkg.sv
// motion_pkg: shared widths, defaults and sequencer types
// for the frame-buffer motion-detection path.
package motion_pkg;
  localparam int RGB_W      = 24;
  localparam int COORD_W    = 10;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } seq_state_t;

  typedef struct packed {
    logic [RGB_W-1:0]   rgb;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_hold_t;
endpackage

// File: rtl/pixel_addr_counter.sv
// pixel_addr_counter: raster x/y plus linear address with
// clear, increment and a full flag at WIDTH*HEIGHT.
module pixel_addr_counter
  import motion_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               full
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_END  = COORD_W'(HEIGHT);

  logic [COORD_W-1:0] bx, by, nx, ny;
  logic [ADDR_W-1:0]  ba, na;

  // clr and inc together land on the position after (0,0)
  always_comb begin
    bx = clr ? '0 : x;
    by = clr ? '0 : y;
    ba = clr ? '0 : addr;
    nx = bx;
    ny = by;
    na = ba;
    if (inc) begin
      na = ba + 1'b1;
      if (bx == X_LAST) begin
        nx = '0;
        ny = by + 1'b1;
      end else begin
        nx = bx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else begin
      x    <= nx;
      y    <= ny;
      addr <= na;
    end
  end

  assign full = (y == Y_END);
endmodule

// File: rtl/motion_frame_sequencer.sv
// motion_frame_sequencer: read-then-overwrite frame buffer
// sequencing, aligned cur/prev pairs for the motion detector.
module motion_frame_sequencer
  import motion_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cam_vsync,
  input  logic               cam_valid,
  input  logic [RGB_W-1:0]   cam_rgb,
  input  logic               clr_flags,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [RGB_W-1:0]   mem_wdata,
  input  logic [RGB_W-1:0]   mem_rdata,
  output logic               det_frame_start,
  output logic               det_valid,
  output logic [COORD_W-1:0] det_x,
  output logic [COORD_W-1:0] det_y,
  output logic [RGB_W-1:0]   det_cur_rgb,
  output logic [RGB_W-1:0]   det_prev_rgb,
  output logic               det_prev_ok,
  output logic               busy,
  output logic               overflow,
  output logic               overrun
);
  seq_state_t state, state_n;
  pix_hold_t  hold;

  logic pending, prev_ok, frame_bad;
  logic vs_apply, accept, pend_set;
  logic drop_busy, drop_full;

  logic [COORD_W-1:0] cnt_x, cnt_y;
  logic [ADDR_W-1:0]  cnt_addr;
  logic               cnt_full;

  pixel_addr_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (vs_apply),
    .inc (accept),
    .x   (cnt_x),
    .y   (cnt_y),
    .addr(cnt_addr),
    .full(cnt_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // vsync is applied before any accept in the same cycle
  always_comb begin
    state_n   = state;
    vs_apply  = 1'b0;
    accept    = 1'b0;
    pend_set  = 1'b0;
    drop_busy = 1'b0;
    drop_full = 1'b0;
    unique case (state)
      IDLE: vs_apply = cam_vsync;
      READ: begin
        state_n   = WRITE;
        drop_busy = cam_valid;
        pend_set  = cam_vsync;
      end
      WRITE: begin
        state_n  = IDLE;
        vs_apply = pending | cam_vsync;
      end
      default: state_n = IDLE;
    endcase
    if (cam_valid && state != READ) begin
      if (vs_apply || !cnt_full) begin
        accept  = 1'b1;
        state_n = READ;
      end else begin
        drop_full = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold            <= '0;
      pending         <= 1'b0;
      prev_ok         <= 1'b0;
      frame_bad       <= 1'b0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      det_frame_start <= 1'b0;
      det_valid       <= 1'b0;
      det_x           <= '0;
      det_y           <= '0;
      det_cur_rgb     <= '0;
      det_prev_rgb    <= '0;
      det_prev_ok     <= 1'b0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      mem_we          <= (state == READ);
      busy            <= (state_n != IDLE);
      det_valid       <= (state == WRITE);
      det_frame_start <= vs_apply;
      pending   <= vs_apply ? 1'b0 : (pending | pend_set);
      frame_bad <= vs_apply ? 1'b0
                 : (frame_bad | drop_busy | drop_full);
      overflow  <= drop_busy | (overflow & ~clr_flags);
      overrun   <= drop_full | (overrun & ~clr_flags);
      if (vs_apply) prev_ok <= cnt_full & ~frame_bad;
      // an in-flight pixel still reports its own frame's status
      det_prev_ok <= (vs_apply && state != WRITE)
                   ? (cnt_full & ~frame_bad) : prev_ok;
      if (accept) begin
        hold.rgb <= cam_rgb;
        hold.x   <= vs_apply ? '0 : cnt_x;
        hold.y   <= vs_apply ? '0 : cnt_y;
        mem_addr <= vs_apply ? '0 : cnt_addr;
      end
      if (state == READ) mem_wdata <= hold.rgb;
      if (state == WRITE) begin
        det_x        <= hold.x;
        det_y        <= hold.y;
        det_cur_rgb  <= hold.rgb;
        det_prev_rgb <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_motion_frame_sequencer.sv
// tb_motion_frame_sequencer: directed and random frames on a
// 4x2 raster, checked against a frame-image reference model.
module tb_motion_frame_sequencer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cam_vsync = 1'b0;
  logic          cam_valid = 1'b0;
  logic [23:0]   cam_rgb = '0;
  logic          clr_flags = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  logic          det_frame_start, det_valid;
  logic [9:0]    det_x, det_y;
  logic [23:0]   det_cur_rgb, det_prev_rgb;
  logic          det_prev_ok, busy, overflow, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          x;
    int          y;
    int          addr;
    logic [23:0] cur;
    logic [23:0] prev;
    logic        ok;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        wr_q[$];
  logic [23:0] sram [0:(1<<AW)-1];
  logic [23:0] img  [0:N-1];
  bit          sram_clr = 1'b1;
  int          m_acc, m_arr;
  logic        m_prev_ok;

  always #5 clk = ~clk;

  motion_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cam_vsync(cam_vsync), .cam_valid(cam_valid),
    .cam_rgb(cam_rgb), .clr_flags(clr_flags),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .det_frame_start(det_frame_start), .det_valid(det_valid),
    .det_x(det_x), .det_y(det_y),
    .det_cur_rgb(det_cur_rgb), .det_prev_rgb(det_prev_rgb),
    .det_prev_ok(det_prev_ok), .busy(busy),
    .overflow(overflow), .overrun(overrun)
  );

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= '0;
    end else begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (det_valid) begin
        if (exp_q.size() == 0) chk("det_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("det_x", det_x, e.x);
          chk("det_y", det_y, e.y);
          chk("det_cur", det_cur_rgb, e.cur);
          chk("det_prev", det_prev_rgb, e.prev);
          chk("det_prev_ok", det_prev_ok, e.ok);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.cur);
        end
      end
    end
  end

  task automatic m_reset();
    m_acc = 0;
    m_arr = 0;
    m_prev_ok = 1'b0;
  endtask

  task automatic m_vsync();
    m_prev_ok = (m_arr == N);
    m_acc = 0;
    m_arr = 0;
  endtask

  task automatic m_pixel(input logic [23:0] rgb);
    exp_t e;
    m_arr++;
    if (m_acc < N) begin
      e.x = m_acc % W;
      e.y = m_acc / W;
      e.addr = m_acc;
      e.cur = rgb;
      e.prev = img[m_acc];
      e.ok = m_prev_ok;
      img[m_acc] = rgb;
      exp_q.push_back(e);
      wr_q.push_back(e);
      m_acc++;
    end
  endtask

  task automatic m_drop();
    m_arr++;
  endtask

  task automatic m_abandon();
    if (exp_q.size() > 0) img[exp_q[$].addr] = exp_q[$].prev;
    exp_q.delete();
    wr_q.delete();
    m_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vsync();
    cam_vsync = 1'b1;
    m_vsync();
    tick();
    cam_vsync = 1'b0;
    chk("fs_pulse", det_frame_start, 1);
    tick();
    chk("fs_single", det_frame_start, 0);
  endtask

  task automatic send_pixel(input logic [23:0] rgb);
    cam_valid = 1'b1;
    cam_rgb = rgb;
    m_pixel(rgb);
    tick();
    cam_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_run(input int n);
    for (int i = 0; i < n; i++) begin
      cam_valid = 1'b1;
      cam_rgb = 24'($urandom);
      m_pixel(cam_rgb);
      tick();
      cam_valid = 1'b0;
      tick();
    end
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_dv"}, det_valid, 0);
    chk({tag, "_fs"}, det_frame_start, 0);
    chk({tag, "_xy"}, {det_x, det_y}, 0);
    chk({tag, "_rgb"}, {det_cur_rgb, det_prev_rgb}, 0);
    chk({tag, "_ok"}, det_prev_ok, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flags"}, {overflow, overrun}, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) img[i] = '0;
    m_reset();
    tick();
    tick();
    check_reset_outputs("rst0");
    sram_clr = 1'b0;
    rst = 1'b0;
    tick();

    // single pixel, cycle-exact
    send_vsync();
    cam_rgb = 24'h112233;
    cam_valid = 1'b1;
    m_pixel(cam_rgb);
    tick();
    chk("t1_rd_addr", mem_addr, 0);
    chk("t1_rd_we", mem_we, 0);
    chk("t1_busy", busy, 1);
    cam_valid = 1'b0;
    tick();
    chk("t1_wr_we", mem_we, 1);
    chk("t1_wr_data", mem_wdata, 24'h112233);
    chk("t1_no_det", det_valid, 0);
    tick();
    chk("t1_det", det_valid, 1);
    chk("t1_xy", {det_x, det_y}, 0);
    chk("t1_ok", det_prev_ok, 0);
    chk("t1_we_off", mem_we, 0);
    tick();
    chk("t1_det_1cyc", det_valid, 0);

    // two full frames
    send_vsync();
    for (int i = 0; i < N; i++)
      send_pixel(i == 5 ? 24'h010203 : 24'($urandom));
    send_vsync();
    for (int i = 0; i < N; i++) begin
      send_pixel(i == 5 ? 24'hAABBCC : 24'($urandom));
      if (i == 5) begin
        chk("t2_prev", det_prev_rgb, 24'h010203);
        chk("t2_ok", det_prev_ok, 1);
        chk("t2_xy", {det_x, det_y}, {10'd1, 10'd1});
      end
    end

    // overflow and clear, then set beating clear
    send_vsync();
    cam_valid = 1'b1;
    cam_rgb = 24'($urandom);
    m_pixel(cam_rgb);
    tick();
    cam_rgb = 24'($urandom);
    m_drop();
    tick();
    cam_valid = 1'b0;
    tick();
    chk("ovf_set", overflow, 1);
    tick();
    tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovr_quiet", overrun, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_clr", overflow, 0);
    cam_valid = 1'b1;
    cam_rgb = 24'($urandom);
    m_pixel(cam_rgb);
    tick();
    clr_flags = 1'b1;
    m_drop();
    tick();
    cam_valid = 1'b0;
    clr_flags = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // vsync during READ of the last pixel
    send_vsync();
    for (int i = 0; i < N - 1; i++) send_pixel(24'($urandom));
    cam_valid = 1'b1;
    cam_rgb = 24'($urandom);
    m_pixel(cam_rgb);
    tick();
    cam_valid = 1'b0;
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
    m_vsync();
    chk("t4_fs_early", det_frame_start, 0);
    tick();
    chk("t4_det", det_valid, 1);
    chk("t4_fs", det_frame_start, 1);
    chk("t4_xy", {det_x, det_y}, {10'd3, 10'd1});
    tick();
    chk("t4_fs_off", det_frame_start, 0);
    send_pixel(24'($urandom));
    chk("t4_next_xy", {det_x, det_y}, 0);
    chk("t4_next_ok", det_prev_ok, 1);

    // vsync together with a pixel in IDLE
    send_pixel(24'($urandom));
    cam_vsync = 1'b1;
    cam_valid = 1'b1;
    cam_rgb = 24'($urandom);
    m_vsync();
    m_pixel(cam_rgb);
    tick();
    cam_vsync = 1'b0;
    cam_valid = 1'b0;
    chk("sim_fs", det_frame_start, 1);
    chk("sim_busy", busy, 1);
    tick();
    tick();
    chk("sim_det", det_valid, 1);
    chk("sim_xy", {det_x, det_y}, 0);

    // overrun: one pixel too many
    send_vsync();
    for (int i = 0; i < N + 1; i++) send_pixel(24'($urandom));
    chk("ovr_set", overrun, 1);
    chk("ovr_idle", busy, 0);
    send_vsync();
    send_pixel(24'($urandom));
    chk("ovr_prev_ok", det_prev_ok, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovr_clr", overrun, 0);

    // reset while in WRITE
    cam_valid = 1'b1;
    cam_rgb = 24'($urandom);
    m_pixel(cam_rgb);
    tick();
    cam_valid = 1'b0;
    tick();
    chk("t6_in_write", mem_we, 1);
    rst = 1'b1;
    m_abandon();
    #1;
    check_reset_outputs("rst_async");
    tick();
    chk("rst_we_edge", mem_we, 0);
    rst = 1'b0;
    tick();
    send_vsync();
    send_pixel(24'($urandom));
    chk("rst_prev_ok", det_prev_ok, 0);

    // random frames
    for (int f = 0; f < 8; f++) begin
      int np;
      np = ($urandom_range(0, 2) == 0)
         ? N - 1 + 2 * int'($urandom_range(0, 1)) : N;
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      send_vsync();
      if ($urandom_range(0, 1) == 1) begin
        send_run(np);
      end else begin
        for (int i = 0; i < np; i++) begin
          send_pixel(24'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      chk("rnd_overrun", overrun, np > N);
      chk("rnd_overflow", overflow, 0);
    end

    tick();
    tick();
    tick();
    chk("drain_det", exp_q.size(), 0);
    chk("drain_wr", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/motion_frame_sequencer.md
# motion_frame_sequencer

Sequences the single-port frame-buffer SRAM for the motion-detection path. Each incoming camera pixel triggers a read of the co-located previous-frame pixel and then an overwrite with the current pixel. The aligned current/previous pair, with coordinates, is presented to the motion detector. The block also generates the detector's frame boundary pulse and reports pixel overflow and frame overrun.

## Interface
Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- ADDR_W, 19, SRAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cam_vsync  in  1  one-cycle frame-start pulse from camera
- cam_valid  in  1  pixel strobe
- cam_rgb  in  24  {R,G,B} 8 bits each
- clr_flags  in  1  synchronous clear of sticky flags
- mem_addr  out  ADDR_W  SRAM address
- mem_we  out  1  SRAM write enable
- mem_wdata  out  24  SRAM write data
- mem_rdata  in  24  SRAM read data, 1-cycle synchronous latency
- det_frame_start  out  1  one-cycle pulse to detector
- det_valid  out  1  pair valid
- det_x, det_y  out  10 each  pixel coordinates
- det_cur_rgb, det_prev_rgb  out  24 each  current / previous pixel
- det_prev_ok  out  1  previous frame was complete; det_prev_rgb is meaningful
- busy  out  1  state ≠ IDLE
- overflow  out  1  sticky: pixel dropped, block busy
- overrun  out  1  sticky: pixel beyond WIDTH*HEIGHT in frame

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE + cam_valid: capture cam_rgb and the current address/x/y into holding registers, then go to READ.
- READ: mem_addr = held address, mem_we = 0. Go to WRITE.
- WRITE:
  - Capture mem_rdata as previous pixel.
  - mem_addr = held address, mem_we = 1, mem_wdata = held pixel.
  - Increment the address/x/y counter. x wraps at WIDTH−1 to 0 with y+1.
  - If cam_valid is high this cycle, accept the pixel and go to READ (back-to-back). Otherwise go to IDLE.
- cam_valid in READ: pixel dropped, overflow ← 1.
- Maximum sustained rate is one pixel per 2 clk.
- Counter at WIDTH*HEIGHT: further pixels in the same frame are dropped without memory access, and overrun ← 1.
- cam_vsync handling:
  - In IDLE with no accept: counters ← 0; det_frame_start pulses the next cycle.
  - In READ or WRITE: latch pending_vsync. It is applied in the cycle the in-flight pixel leaves WRITE. Counters reset before any back-to-back accept in that cycle. det_frame_start pulses with or after that pixel's det_valid, never before.
  - Simultaneous with cam_valid in IDLE: vsync applies first, and the pixel becomes (0,0) of the new frame.
- Frame completion:
  - At each applied vsync, prev_ok_next ← (pixel count of the ending frame == WIDTH*HEIGHT).
  - det_prev_ok takes prev_ok_next for the whole new frame.
  - After reset, det_prev_ok = 0 until a full frame has been stored.
- Sticky flags clear on clr_flags. If a set event occurs in the same cycle as clr_flags, the set wins.
- Reset (any time, including mid-pixel): FSM → IDLE; counters, pending_vsync and prev_ok ← 0. The in-flight pixel is abandoned with no write.

## Timing
- All outputs are registered. Reset values: mem_we 0, mem_addr 0, mem_wdata 0, det_* 0, busy 0, overflow 0, overrun 0.
- Pixel accepted at cycle t (IDLE):
  - READ at t+1.
  - WRITE at t+2; mem_rdata is valid at t+2.
  - det_valid = 1 for exactly one cycle at t+3, carrying x, y, cur, prev.
- Back-to-back: pixels accepted at t and t+2 give det_valid at t+3 and t+5.
- det_frame_start: 1 cycle after vsync in IDLE. When deferred, in the cycle after the last in-flight WRITE.
- mem_we is high only in WRITE cycles.

## Structure
- Shared package motion_pkg holds:
  - RGB_W = 24
  - default WIDTH/HEIGHT
  - state enum {IDLE, READ, WRITE}
- Sub-module pixel_addr_counter: x/y/linear address with clear, increment and a full flag at WIDTH*HEIGHT. It is reused by the VGA readout path.

## Test plan
- Reset, vsync, one pixel 0x112233 → SRAM sees read@0 then write@0 = 0x112233. det_valid at t+3 with x=0, y=0, det_prev_ok=0.
- Two full frames with WIDTH=4, HEIGHT=2; frame 2 pixel (1,1) = 0xAABBCC, frame 1 pixel (1,1) = 0x010203 → det_prev_rgb = 0x010203, det_prev_ok = 1, addr 5.
- cam_valid on consecutive cycles → second pixel dropped, overflow = 1 until clr_flags.
- vsync during READ of pixel (3,1) → that pixel is written at addr 7. det_frame_start is not before its det_valid. The next pixel maps to (0,0).
- 9 pixels in a 4×2 frame → 9th produces no mem access and overrun = 1. Next frame det_prev_ok = 0.
- rst asserted in WRITE → mem_we is 0 on the next edge and all outputs return to reset values.
